// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, then a one-cycle sign fix.
// Define DIV_SIGNED_EN to honour 'unsign'; otherwise every operation is unsigned.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             unsign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: 'start' is sampled only while busy=0; a sampled start is the
  // accept. 'done' is a one-cycle pulse with Q/R/div_zero valid in that cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic             a_neg;
  logic             d_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             d_is_zero;

`ifdef DIV_SIGNED_EN
  always_comb begin
    a_neg = ~unsign & A[WIDTH-1];
    d_neg = ~unsign & D[WIDTH-1];
  end
`else
  logic unused_unsign;
  assign unused_unsign = unsign;
  always_comb begin
    a_neg = 1'b0;
    d_neg = 1'b0;
  end
`endif

  // The most negative value maps onto 2^(WIDTH-1) unsigned, which the
  // magnitude datapath handles without a special case.
  always_comb begin
    a_mag     = a_neg ? ({WIDTH{1'b0}} - A) : A;
    d_mag     = d_neg ? ({WIDTH{1'b0}} - D) : D;
    d_is_zero = (D == {WIDTH{1'b0}});
  end

  // Partial remainder stays below the divisor, so the shifted value fits in
  // WIDTH+1 bits and the top bit of the difference is the borrow.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = d_is_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == {CW{1'b0}}) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= {CW{1'b0}};
      dvd      <= {WIDTH{1'b0}};
      dvs      <= {WIDTH{1'b0}};
      rem      <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      Q        <= {WIDTH{1'b0}};
      R        <= {WIDTH{1'b0}};
      div_zero <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        if (d_is_zero) begin
          Q        <= {WIDTH{1'b1}};
          R        <= A;
          div_zero <= 1'b1;
        end else begin
          dvd   <= a_mag;
          dvs   <= d_mag;
          rem   <= {WIDTH{1'b0}};
          neg_q <= a_neg ^ d_neg;
          neg_r <= a_neg;
          cnt   <= CW'(WIDTH - 1);
        end
      end

      // dvd shifts the dividend out at the top and the quotient in at the bottom
      if (state == RUN) begin
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], 1'b1};
        end else begin
          rem <= rem_shift[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], 1'b0};
        end
        if (cnt != {CW{1'b0}}) begin
          cnt <= cnt - CW'(1);
        end
      end

      if (state == FIX) begin
        Q        <= neg_q ? ({WIDTH{1'b0}} - dvd) : dvd;
        R        <= neg_r ? ({WIDTH{1'b0}} - rem) : rem;
        div_zero <= 1'b0;
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic reference model plus literal pins.
// Signed vectors switch expectations when DIV_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;
  localparam int NV    = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             unsign = 1'b1;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] d_in = '0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_r[$];
  logic             exp_dz[$];
  int               exp_t[$];

  logic [WIDTH-1:0] last_q = '0;
  logic [WIDTH-1:0] last_r = '0;
  logic             last_dz = 1'b0;

  logic [WIDTH-1:0] tv_a[NV];
  logic [WIDTH-1:0] tv_d[NV];
  logic             tv_u[NV];
  logic [WIDTH-1:0] tv_q[NV];
  logic [WIDTH-1:0] tv_r[NV];

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .unsign    (unsign),
    .A         (a_in),
    .D         (d_in),
    .Q         (q),
    .R         (r),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d, input logic uns,
                       output logic [WIDTH-1:0] mq, output logic [WIDTH-1:0] mr, output logic mdz);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0] min_val;
    min_val = {1'b1, {(WIDTH-1){1'b0}}};
    sa = a;
    sd = d;
    mdz = 1'b0;
    if (d == '0) begin
      mq  = '1;
      mr  = a;
      mdz = 1'b1;
    end else begin
      mq = a / d;
      mr = a % d;
`ifdef DIV_SIGNED_EN
      if (!uns) begin
        if (a == min_val && d == '1) begin
          mq = a;
          mr = '0;
        end else begin
          mq = sa / sd;
          mr = sa % sd;
        end
      end
`else
      if (uns) mq = a / d;
`endif
    end
  endtask

  task automatic chk(input string nm, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d, input logic uns, input int t);
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mr;
    logic             mdz;
    model(a, d, uns, mq, mr, mdz);
    exp_q.push_back(mq);
    exp_r.push_back(mr);
    exp_dz.push_back(mdz);
    exp_t.push_back(t + ((d == '0) ? 1 : LAT));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d, input logic uns, input bit accept);
    int t;
    @(negedge clk);
    a_in = a;
    d_in = d;
    unsign = uns;
    start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) push(a, d, uns, t);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk({nm, "_done_seen"}, {31'b0, done}, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_q", q, '0);
    chk("rst_r", r, '0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_div_zero", {31'b0, div_zero}, 0);
    exp_q.delete();
    exp_r.delete();
    exp_dz.delete();
    exp_t.delete();
    last_q = '0;
    last_r = '0;
    last_dz = 1'b0;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic exp_busy;
    if (rst_n) begin
      exp_busy = (exp_q.size() != 0);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 with no operation outstanding, required 0");
        end else begin
          chk("q", q, exp_q.pop_front());
          chk("r", r, exp_r.pop_front());
          chk("div_zero", {31'b0, div_zero}, {31'b0, exp_dz.pop_front()});
          chk("done_cycle", cyc, exp_t.pop_front());
        end
        last_q = q;
        last_r = r;
        last_dz = div_zero;
      end else begin
        chk("hold_q", q, last_q);
        chk("hold_r", r, last_r);
        chk("hold_div_zero", {31'b0, div_zero}, {31'b0, last_dz});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int t;

    tv_a[0]  = 32'd0;          tv_d[0]  = 32'd5;          tv_u[0]  = 1'b1; tv_q[0]  = 32'd0;          tv_r[0]  = 32'd0;
    tv_a[1]  = 32'd5;          tv_d[1]  = 32'd7;          tv_u[1]  = 1'b1; tv_q[1]  = 32'd0;          tv_r[1]  = 32'd5;
    tv_a[2]  = 32'hFFFFFFFF;   tv_d[2]  = 32'd1;          tv_u[2]  = 1'b1; tv_q[2]  = 32'hFFFFFFFF;   tv_r[2]  = 32'd0;
    tv_a[3]  = 32'hFFFFFFFF;   tv_d[3]  = 32'hFFFFFFFF;   tv_u[3]  = 1'b1; tv_q[3]  = 32'd1;          tv_r[3]  = 32'd0;
    tv_a[4]  = 32'h80000000;   tv_d[4]  = 32'd2;          tv_u[4]  = 1'b1; tv_q[4]  = 32'h40000000;   tv_r[4]  = 32'd0;
    tv_a[5]  = 32'd1234567;    tv_d[5]  = 32'd1000;       tv_u[5]  = 1'b1; tv_q[5]  = 32'd1234;       tv_r[5]  = 32'd567;
    tv_a[6]  = 32'hFFFFFFF9;   tv_d[6]  = 32'd2;          tv_u[6]  = 1'b1; tv_q[6]  = 32'h7FFFFFFC;   tv_r[6]  = 32'd1;
    tv_a[7]  = 32'hFFFFFFF9;   tv_d[7]  = 32'd2;          tv_u[7]  = 1'b0;
    tv_a[8]  = 32'h80000000;   tv_d[8]  = 32'hFFFFFFFF;   tv_u[8]  = 1'b0;
    tv_a[9]  = 32'd7;          tv_d[9]  = 32'hFFFFFFFE;   tv_u[9]  = 1'b0;
    tv_a[10] = 32'hFFFFFFF9;   tv_d[10] = 32'hFFFFFFFE;   tv_u[10] = 1'b0;
`ifdef DIV_SIGNED_EN
    tv_q[7] = 32'hFFFFFFFD; tv_r[7] = 32'hFFFFFFFF;
    tv_q[8] = 32'h80000000; tv_r[8] = 32'd0;
    tv_q[9] = 32'hFFFFFFFD; tv_r[9] = 32'd1;
    tv_q[10] = 32'd3;       tv_r[10] = 32'hFFFFFFFF;
`else
    tv_q[7] = 32'h7FFFFFFC; tv_r[7] = 32'd1;
    tv_q[8] = 32'd0;        tv_r[8] = 32'h80000000;
    tv_q[9] = 32'd0;        tv_r[9] = 32'd7;
    tv_q[10] = 32'd0;       tv_r[10] = 32'hFFFFFFF9;
`endif

    // asynchronous reset before the first clock edge
    #2;
    apply_reset_now();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // 100/7 with an ignored start ten cycles into the run
    d0 = done_cnt;
    drive(32'd100, 32'd7, 1'b1, 1'b1);
    idle(9);
    drive(32'd50, 32'd5, 1'b1, 1'b0);
    wait_done("op_100_7", 80);
    chk("lit_100_7_q", q, 32'd14);
    chk("lit_100_7_r", r, 32'd2);
    chk("lit_100_7_dz", {31'b0, div_zero}, 0);
    idle(6);
    chk("done_count_100_7", done_cnt - d0, 1);

    // divide by zero
    drive(32'h12345678, 32'd0, 1'b1, 1'b1);
    wait_done("op_div0", 10);
    chk("lit_div0_q", q, 32'hFFFFFFFF);
    chk("lit_div0_r", r, 32'h12345678);
    chk("lit_div0_dz", {31'b0, div_zero}, 1);
    idle(3);

    // start in DONE is ignored, start in the following IDLE cycle is taken
    drive(32'd1000, 32'd10, 1'b1, 1'b1);
    wait_done("op_1000_10", 80);
    chk("lit_1000_10_q", q, 32'd100);
    a_in = 32'h0000DEAD;
    d_in = 32'd3;
    start = 1'b1;
    @(negedge clk);
    a_in = 32'd200;
    d_in = 32'd9;
    unsign = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(32'd200, 32'd9, 1'b1, t);
    wait_done("op_200_9", 80);
    chk("lit_200_9_q", q, 32'd22);
    chk("lit_200_9_r", r, 32'd2);

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      drive(tv_a[i], tv_d[i], tv_u[i], 1'b1);
      wait_done($sformatf("vec%0d", i), 80);
      chk($sformatf("lit_vec%0d_q", i), q, tv_q[i]);
      chk($sformatf("lit_vec%0d_r", i), r, tv_r[i]);
    end
    idle(2);

    // reset in the middle of a run, then a start on the first edge after release
    drive(32'd1000, 32'd3, 1'b1, 1'b1);
    idle(14);
    #2;
    apply_reset_now();
    idle(2);
    rst_n = 1'b1;
    a_in = 32'd9;
    d_in = 32'd3;
    unsign = 1'b1;
    start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(32'd9, 32'd3, 1'b1, t);
    wait_done("op_9_3", 80);
    chk("lit_9_3_q", q, 32'd3);
    chk("lit_9_3_r", r, 32'd0);
    idle(5);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
